// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants for the data-memory access controller: access sizes (funct3),
// FSM states, requester ids and the latched request record.
package dmem_access_ctrl_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        port;
  } req_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// One requester's request/response handshake toward the data-memory controller.
// The requester uses the master modport, the controller the slave modport.
interface dmem_access_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid
  );

endinterface

// File: rtl/dmem_access_ctrl_lane_align.sv
// Combinational byte-lane logic: store mask/data replication, load extract with
// sign/zero extension, and misaligned/illegal-size detection.
module dmem_access_ctrl_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rd,
  output logic        err,
  output logic [3:0]  wmask,
  output logic [31:0] wd,
  output logic [31:0] rdata
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = rd[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? rd[31:16] : rd[15:0];
    err     = 1'b0;
    wmask   = 4'b0000;
    wd      = wdata;
    rdata   = 32'b0;

    case (size)
      SZ_B, SZ_BU: begin
        wmask = 4'b0001 << lane;
        wd    = {4{wdata[7:0]}};
        rdata = (size == SZ_B) ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
      end
      SZ_H, SZ_HU: begin
        err   = lane[0];
        wmask = 4'b0011 << {lane[1], 1'b0};
        wd    = {2{wdata[15:0]}};
        rdata = (size == SZ_H) ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
      end
      SZ_W: begin
        err   = (lane != 2'b00);
        wmask = 4'b1111;
        wd    = wdata;
        rdata = rd;
      end
      default: err = 1'b1;
    endcase

    // Unsigned sizes have no store form.
    if (we && size[2]) err = 1'b1;
    if (err || !we)    wmask = 4'b0000;
    if (err || we)     rdata = 32'b0;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates core and DMA onto one data memory: accept N, memory access N+1, response
// from N+2, held until the owner's resp_ready; one access in flight, ready only in IDLE.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_access_ctrl_if.slave core,
  dmem_access_ctrl_if.slave dma,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dmem_we,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wd,
  output logic [ADDR_W-1:0] dmem_a,
  input  logic [31:0]       dmem_rd
);

  state_t state, state_nxt;
  req_t   req_q, req_in;
  logic   last_grant;
  logic   grant_dma;
  logic   accept;
  logic   al_err;
  logic   [3:0]  al_wmask;
  logic   [31:0] al_rdata;
  logic   unused_addr;

  // On a tie, round-robin hands the grant to whoever did not win last time.
  always_comb begin
    if (core.req_valid && dma.req_valid) grant_dma = RR_EN ? (last_grant == PORT_CORE) : 1'b0;
    else                                 grant_dma = dma.req_valid;
    accept = (state == ST_IDLE) && (core.req_valid || dma.req_valid);
  end

  always_comb begin
    req_in.we    = grant_dma ? dma.req_we    : core.req_we;
    req_in.size  = grant_dma ? dma.req_size  : core.req_size;
    req_in.addr  = grant_dma ? dma.req_addr  : core.req_addr;
    req_in.wdata = grant_dma ? dma.req_wdata : core.req_wdata;
    req_in.port  = grant_dma ? PORT_DMA : PORT_CORE;
  end

  always_comb begin
    state_nxt       = state;
    core.req_ready  = 1'b0;
    dma.req_ready   = 1'b0;
    core.resp_valid = 1'b0;
    dma.resp_valid  = 1'b0;
    dmem_we         = 1'b0;
    dmem_wmask      = 4'b0000;
    case (state)
      ST_IDLE: begin
        if (!rst) begin
          core.req_ready = core.req_valid && !grant_dma;
          dma.req_ready  = grant_dma;
        end
        if (accept) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Reset landing on the memory cycle must not leave a partial store behind.
        dmem_we    = req_q.we && !al_err && !rst;
        dmem_wmask = rst ? 4'b0000 : al_wmask;
        state_nxt  = ST_RESP;
      end
      ST_RESP: begin
        core.resp_valid = !rst && (req_q.port == PORT_CORE);
        dma.resp_valid  = !rst && (req_q.port == PORT_DMA);
        if ((req_q.port == PORT_DMA) ? dma.resp_ready : core.resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= PORT_DMA;
      req_q      <= '0;
      resp_rdata <= 32'b0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q      <= req_in;
        last_grant <= req_in.port;
      end
      if (state == ST_ACCESS) begin
        resp_rdata <= al_rdata;
        resp_err   <= al_err;
      end
    end
  end

  dmem_access_ctrl_lane_align u_align (
    .we    (req_q.we),
    .size  (req_q.size),
    .lane  (req_q.addr[1:0]),
    .wdata (req_q.wdata),
    .rd    (dmem_rd),
    .err   (al_err),
    .wmask (al_wmask),
    .wd    (dmem_wd),
    .rdata (al_rdata)
  );

  // Address bits above the memory size wrap silently.
  assign dmem_a      = req_q.addr[ADDR_W+1:2];
  assign unused_addr = ^req_q.addr;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus random traffic, checked against a
// byte-addressed reference memory and access rules computed with plain arithmetic.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_access_ctrl_if core_if ();
  dmem_access_ctrl_if dma_if ();
  dmem_access_ctrl_if fp_core_if ();
  dmem_access_ctrl_if fp_dma_if ();

  logic [31:0] resp_rdata, dmem_wd, dmem_rd;
  logic        resp_err, dmem_we;
  logic [3:0]  dmem_wmask;
  logic [9:0]  dmem_a;
  logic [31:0] fp_rdata, fp_wd, fp_rd;
  logic        fp_err, fp_we;
  logic [3:0]  fp_wmask;
  logic [9:0]  fp_a;

  dmem_access_ctrl #(.ADDR_W(10), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .core(core_if), .dma(dma_if),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dmem_we(dmem_we),
    .dmem_wmask(dmem_wmask), .dmem_wd(dmem_wd), .dmem_a(dmem_a), .dmem_rd(dmem_rd)
  );

  dmem_access_ctrl #(.ADDR_W(10), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .core(fp_core_if), .dma(fp_dma_if),
    .resp_rdata(fp_rdata), .resp_err(fp_err), .dmem_we(fp_we),
    .dmem_wmask(fp_wmask), .dmem_wd(fp_wd), .dmem_a(fp_a), .dmem_rd(fp_rd)
  );
  assign fp_rd = 32'h0;

  int vectors = 0;
  int miscompares = 0;
  int we_cycles = 0;
  int both_ready = 0;

  // Memory array driven by the DUT, plus the bench's own byte-level reference copy.
  logic [31:0] mem [0:1023];
  logic [7:0]  ref_mem [0:4095];
  logic        mem_init;
  assign dmem_rd = mem[dmem_a];

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int w = 0; w < 1024; w++) mem[w] <= init_word(w);
    end else if (dmem_we) begin
      for (int l = 0; l < 4; l++)
        if (dmem_wmask[l]) mem[dmem_a][8*l +: 8] <= dmem_wd[8*l +: 8];
    end
  end

  always @(negedge clk) begin
    if (dmem_we) we_cycles++;
    if (core_if.req_ready && dma_if.req_ready) both_ready++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: one access applied to the byte memory, with size/alignment legality.
  task automatic ref_access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                            output logic [3:0] mask, output logic [31:0] wd_full);
    int n, a;
    logic [31:0] v;
    a = int'(addr % 32'd4096);
    case (sz)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    if (n == 0) err = 1'b1;
    else        err = (we && sz >= 3'd4) || ((a % n) != 0);
    rdata = 32'h0; mask = 4'h0; wd_full = 32'h0;
    if (!err && we) begin
      for (int i = 0; i < n; i++) ref_mem[a+i] = 8'(wdata >> (8*i));
      mask    = 4'(((1 << n) - 1) << (a % 4));
      wd_full = (n == 1) ? 32'(wdata[7:0]) * 32'h01010101 :
                (n == 2) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
    end else if (!err) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
      if (sz < 3'd4 && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      rdata = v;
    end
  endtask

  task automatic drive_req(input bit p, input logic v, input logic we, input logic [2:0] sz,
                           input logic [31:0] ad, input logic [31:0] wd);
    if (p) begin
      dma_if.req_valid = v; dma_if.req_we = we; dma_if.req_size = sz;
      dma_if.req_addr = ad; dma_if.req_wdata = wd;
    end else begin
      core_if.req_valid = v; core_if.req_we = we; core_if.req_size = sz;
      core_if.req_addr = ad; core_if.req_wdata = wd;
    end
  endtask

  task automatic set_rr(input bit p, input logic v);
    if (p) dma_if.resp_ready = v; else core_if.resp_ready = v;
  endtask

  function automatic logic rdy(input bit p);
    return p ? dma_if.req_ready : core_if.req_ready;
  endfunction

  function automatic logic rvld(input bit p);
    return p ? dma_if.resp_valid : core_if.resp_valid;
  endfunction

  // One complete access from port p; the response is held back for 'hold' extra cycles.
  task automatic run_xact(input bit p, input logic we, input logic [2:0] sz, input logic [31:0] ad,
                          input logic [31:0] wd, input int hold, input string tag);
    logic e_err; logic [31:0] e_rd; logic [3:0] e_mask; logic [31:0] e_wd;
    int t, we0;
    ref_access(we, sz, ad, wd, e_err, e_rd, e_mask, e_wd);
    we0 = we_cycles;
    drive_req(p, 1'b1, we, sz, ad, wd);
    #1;
    t = 0;
    while (!rdy(p) && t < 20) begin @(negedge clk); #1; t++; end
    checkb({tag, " grant"}, rdy(p), 1'b1);
    @(posedge clk); #1;
    drive_req(p, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
    @(negedge clk); #1;
    checkb({tag, " acc_we"}, dmem_we, we && !e_err);
    check({tag, " acc_mask"}, 32'(dmem_wmask), 32'(e_mask));
    check({tag, " acc_a"}, 32'(dmem_a), (ad & 32'hFFF) >> 2);
    if (we && !e_err) check({tag, " acc_wd"}, dmem_wd, e_wd);
    checkb({tag, " acc_novld"}, rvld(p), 1'b0);
    checkb({tag, " acc_oth_rdy"}, rdy(!p), 1'b0);
    @(negedge clk); #1;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin @(negedge clk); #1; end
      checkb({tag, " resp_vld"}, rvld(p), 1'b1);
      checkb({tag, " resp_oth_vld"}, rvld(!p), 1'b0);
      checkb({tag, " resp_err"}, resp_err, e_err);
      check({tag, " resp_rdata"}, resp_rdata, e_rd);
      checkb({tag, " resp_oth_rdy"}, rdy(!p), 1'b0);
    end
    set_rr(p, 1'b1);
    @(posedge clk); #1;
    set_rr(p, 1'b0);
    @(negedge clk); #1;
    checkb({tag, " done_vld"}, rvld(p), 1'b0);
    check({tag, " we_cycles"}, 32'(we_cycles - we0), (we && !e_err) ? 32'd1 : 32'd0);
  endtask

  logic [2:0] legal_sz [5];
  logic [2:0] bad_sz [3];
  bit         rr_q [$];
  int         fp_core_g, fp_dma_g, fp_dma_after, t, we0;
  logic       exp_port;
  logic [31:0] word;

  initial begin
    legal_sz = '{SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
    bad_sz   = '{3'b011, 3'b110, 3'b111};
    rst = 1'b1;
    mem_init = 1'b1;
    for (int b = 0; b < 4096; b++) begin
      word = init_word(b / 4);
      ref_mem[b] = word[8*(b%4) +: 8];
    end
    drive_req(0, 1'b1, 1'b1, SZ_W, 32'h0, 32'h0);
    drive_req(1, 1'b1, 1'b1, SZ_W, 32'h4, 32'h0);
    set_rr(0, 1'b0); set_rr(1, 1'b0);
    fp_core_if.req_valid = 1'b1; fp_core_if.req_we = 1'b0; fp_core_if.req_size = SZ_W;
    fp_core_if.req_addr = 32'h0; fp_core_if.req_wdata = 32'h0; fp_core_if.resp_ready = 1'b1;
    fp_dma_if.req_valid = 1'b1; fp_dma_if.req_we = 1'b0; fp_dma_if.req_size = SZ_W;
    fp_dma_if.req_addr = 32'h8; fp_dma_if.req_wdata = 32'h0; fp_dma_if.resp_ready = 1'b1;
    @(posedge clk); #1;
    mem_init = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;

    // Reset: nothing ready, nothing valid, no write even with requests pending.
    checkb("rst core_rdy", core_if.req_ready, 1'b0);
    checkb("rst dma_rdy", dma_if.req_ready, 1'b0);
    checkb("rst core_vld", core_if.resp_valid, 1'b0);
    checkb("rst dma_vld", dma_if.resp_valid, 1'b0);
    check("rst rdata", resp_rdata, 32'h0);
    checkb("rst err", resp_err, 1'b0);
    checkb("rst we", dmem_we, 1'b0);
    check("rst mask", 32'(dmem_wmask), 32'h0);
    checkb("rst fp_rdy", fp_core_if.req_ready, 1'b0);
    drive_req(0, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Contention: round-robin alternates from core; fixed priority serves core only.
    drive_req(0, 1'b1, 1'b0, SZ_W, 32'h0, 32'h0);
    drive_req(1, 1'b1, 1'b0, SZ_W, 32'h4, 32'h0);
    set_rr(0, 1'b1); set_rr(1, 1'b1);
    fp_core_g = 0; fp_dma_g = 0; fp_dma_after = 0;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (core_if.req_valid && core_if.req_ready) rr_q.push_back(1'b0);
      if (dma_if.req_valid && dma_if.req_ready) rr_q.push_back(1'b1);
      if (fp_core_if.req_valid && fp_core_if.req_ready) fp_core_g++;
      if (fp_dma_if.req_valid && fp_dma_if.req_ready) fp_dma_g++;
      @(negedge clk); #1;
    end
    drive_req(0, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
    fp_core_if.req_valid = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (fp_dma_if.req_valid && fp_dma_if.req_ready) fp_dma_after++;
      @(negedge clk); #1;
    end
    fp_dma_if.req_valid = 1'b0;
    set_rr(0, 1'b0); set_rr(1, 1'b0);
    check("rr grant_count", 32'(rr_q.size()), 32'd4);
    exp_port = PORT_DMA;
    foreach (rr_q[k]) begin
      exp_port = !exp_port;
      checkb("rr grant_order", rr_q[k], exp_port);
    end
    check("fp core_grants", 32'(fp_core_g), 32'd4);
    check("fp dma_grants_contended", 32'(fp_dma_g), 32'd0);
    checkb("fp dma_granted_after", fp_dma_after > 0, 1'b1);
    repeat (4) @(negedge clk);
    #1;

    run_xact(0, 1'b1, SZ_W,  32'h10, 32'hDEADBEEF, 0, "t1_sw");
    run_xact(0, 1'b1, SZ_B,  32'h13, 32'h000000A5, 0, "t2_sb");
    run_xact(0, 1'b0, SZ_B,  32'h13, 32'h0, 0, "t2_lb");
    run_xact(0, 1'b0, SZ_BU, 32'h13, 32'h0, 0, "t2_lbu");
    run_xact(0, 1'b0, SZ_H,  32'h11, 32'h0, 0, "t4_lh_mis");
    run_xact(0, 1'b1, SZ_W,  32'h12, 32'h12345678, 0, "t4_sw_mis");
    run_xact(1, 1'b0, SZ_W,  32'h10, 32'h0, 0, "t4_readback");

    // Long response hold with DMA waiting; DMA must win the first IDLE cycle after.
    drive_req(1, 1'b1, 1'b0, SZ_W, 32'h20, 32'h0);
    run_xact(0, 1'b0, SZ_W, 32'h10, 32'h0, 5, "t5_hold");
    checkb("t5 dma_next", dma_if.req_ready, 1'b1);
    run_xact(1, 1'b0, SZ_H, 32'h22, 32'h0, 0, "t5_dma");

    for (int i = 0; i < 60; i++) begin
      int r;
      logic [2:0] sz;
      r  = int'($urandom_range(0, 15));
      sz = (r < 13) ? legal_sz[r % 5] : bad_sz[r - 13];
      run_xact(1'($urandom), 1'($urandom), sz, ($urandom << 12) | $urandom_range(0, 127),
               $urandom, int'($urandom_range(0, 3)), "rnd");
    end

    // Reset during the memory cycle of a store: no write, no response.
    we0 = we_cycles;
    drive_req(0, 1'b1, 1'b1, SZ_W, 32'h40, 32'hCAFEF00D);
    #1;
    t = 0;
    while (!core_if.req_ready && t < 20) begin @(negedge clk); #1; t++; end
    checkb("t6 grant", core_if.req_ready, 1'b1);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk); #1;
    checkb("t6 rst_we", dmem_we, 1'b0);
    check("t6 rst_mask", 32'(dmem_wmask), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checkb("t6 no_resp", core_if.resp_valid, 1'b0);
    check("t6 we_cycles", 32'(we_cycles - we0), 32'd0);
    run_xact(0, 1'b0, SZ_W, 32'h40, 32'h0, 0, "t6_readback");

    checkb("one_ready_max", both_ready == 0, 1'b1);
    for (int w = 0; w < 1024; w++)
      check("mem_final", mem[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
